spi_dev_ctrl: RTL and testbench
===============================

SPI_DEV_CTRL -- requirements
Module: spi_dev_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning bus address width, legal range 8..16; received address bits above ADDR_W are discarded.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port usr_rx_data, input, 8, received byte from the SPI device core.
REQ-005 SHALL have port usr_rx_stb, input, 1, one-cycle strobe marking usr_rx_data valid.
REQ-006 SHALL have port usr_tx_data, output, 8, byte offered to the SPI device core for the next transfer.
REQ-007 SHALL have port usr_tx_ack, input, 1, one-cycle pulse: core has latched usr_tx_data.
REQ-008 SHALL have ports csn_rise and csn_fall, input, 1 each, synchronized chip-select edge pulses.
REQ-009 SHALL have ports bus_addr (output, ADDR_W), bus_wdata (output, 8), bus_we (output, 1) and bus_re (output, 1), forming the register bus master request.
REQ-010 SHALL have ports bus_rdata (input, 8) and bus_ack (input, 1), where bus_ack is a one-cycle completion and bus_rdata is valid with it.
REQ-011 SHALL have ports err_ovr and err_udr, output, 1 each, sticky overrun and underrun flags.

Function
REQ-012 SHALL use the frame format: byte0 command, 0x01 = WRITE, 0x02 = READ; byte1 = address MSB; byte2 = address LSB; then payload bytes.
REQ-013 SHALL implement FSM states IDLE, CMD, ADDR_H, ADDR_L, WDATA, RDUMMY, RDATA and DRAIN.
REQ-014 SHALL move from any state to CMD on csn_fall, and from any state to IDLE on csn_rise.
REQ-015 SHALL, on usr_rx_stb, make these transitions: CMD to ADDR_H for a valid command, otherwise CMD to DRAIN; ADDR_H to ADDR_L; ADDR_L to WDATA (WRITE) or RDUMMY (READ); RDUMMY to RDATA.
REQ-016 SHALL ignore usr_rx_stb in IDLE and DRAIN.
REQ-017 SHALL, on each usr_rx_stb in WDATA, issue a bus write of usr_rx_data to the current address, then increment the address.
REQ-018 SHALL, on usr_rx_stb in ADDR_L for a READ, issue a bus read of the received address.
REQ-019 SHALL, on each usr_rx_stb in RDATA, issue a prefetch bus read of the current address.
REQ-020 SHALL, on bus_ack of a read, load usr_tx_data with bus_rdata and increment the address.
REQ-021 SHALL wrap the address modulo 2^ADDR_W.
REQ-022 SHALL present the first read byte on MISO during the byte after the dummy byte.
REQ-023 SHALL assert bus_we or bus_re (never both) from the cycle after the triggering strobe until and including the bus_ack cycle, with bus_addr and bus_wdata stable throughout.
REQ-024 SHALL allow at most one outstanding bus request; a request in flight SHALL complete even if csn_rise occurs.
REQ-025 SHALL treat usr_rx_stb while a request is in flight, in CMD, ADDR_L, WDATA or RDATA, as an overrun: set err_ovr, drop the byte, and enter DRAIN.
REQ-026 SHALL set err_udr when usr_tx_ack arrives in RDATA while a read is in flight; the stale byte is sent and the read still completes.
REQ-027 SHALL set usr_tx_data to the status byte {6'b0, err_udr, err_ovr} in IDLE.
REQ-028 SHALL clear both error flags on csn_fall, after the status byte has been latched by the core in that cycle.
REQ-029 SHALL, when csn_fall and usr_rx_stb coincide, give csn_fall priority and drop the strobe.
REQ-030 SHALL, when csn_rise and bus_ack coincide, complete the request and move to IDLE.

Reset
REQ-031 SHALL, while rst_n is low, hold the FSM in IDLE, with the address register, usr_tx_data, bus_addr and bus_wdata at 0.
REQ-032 SHALL, while rst_n is low, hold bus_we, bus_re, err_ovr and err_udr at 0.
REQ-033 SHALL abandon any in-flight request on reset assertion mid-operation, with no ack expected.

Structure
REQ-034 SHALL take the command codes (0x01, 0x02) and FSM state encodings from a shared package, spi_dev_ctrl_pkg.
REQ-035 SHALL isolate request, hold and ack tracking in one sub-module, spi_dev_ctrl_bus.

Verification
REQ-036 SHALL cover this directed write: csn_fall, bytes 01 12 34 AA BB -> writes AA@0x1234 and BB@0x1235, no errors.
REQ-037 SHALL cover this directed read: csn_fall, bytes 02 00 10 xx xx xx, bus returns 5A@0x0010 and 6B@0x0011 with 3-cycle ack -> MISO bytes 4 and 5 = 5A, 6B.
REQ-038 SHALL cover address wrap: write at 0xFFFF with two payload bytes -> second write at 0x0000.
REQ-039 SHALL cover an invalid command: byte0 = 0x07 -> DRAIN, no bus cycles until csn_rise.
REQ-040 SHALL cover overrun: bus_ack withheld 40 cycles during WDATA with the next byte arriving -> err_ovr = 1, the next frame's first MISO byte = 0x01, flags then 0.
REQ-041 SHALL cover mid-read reset: rst_n low mid-read -> bus_re = 0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/spi_dev_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_dev_ctrl_pkg
// Shared definitions for the SPI device-side register access controller:
// frame command codes, FSM state encoding, bus operation codes and the
// status byte layout returned on MISO between frames.
// ---------------------------------------------------------------------------
package spi_dev_ctrl_pkg;

    // Frame command codes (first byte of every frame)
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;

    // Frame-decode FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR_H = 3'd2,
        ST_ADDR_L = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDUMMY = 3'd5,
        ST_RDATA  = 3'd6,
        ST_DRAIN  = 3'd7
    } state_t;

    // Request handed from the frame decoder to the bus tracker
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_WR   = 2'd1,
        OP_RD   = 2'd2
    } bus_op_t;

    function automatic logic is_valid_cmd(input logic [7:0] b);
        return (b == CMD_WRITE) || (b == CMD_READ);
    endfunction

    // Byte offered on MISO while no frame is active
    function automatic logic [7:0] status_byte(input logic udr, input logic ovr);
        return {6'b0, udr, ovr};
    endfunction

endpackage

// File: rtl/spi_dev_ctrl_bus.sv
// ---------------------------------------------------------------------------
// spi_dev_ctrl_bus
// Register-bus request tracker. Accepts a single-cycle request from the frame
// decoder, raises bus_we or bus_re the following cycle and holds address and
// write data stable until the cycle bus_ack is seen. Only one request can be
// outstanding; the decoder consults 'busy' before issuing another.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_op               : OP_WR / OP_RD for one cycle to start a request
//   req_addr, req_wdata  : request address and write data (sampled with req_op)
//   busy                 : a request is in flight (including its ack cycle)
//   rd_done              : read completes this cycle (bus_rdata is valid)
//   bus_addr, bus_wdata  : register bus address / write data
//   bus_we, bus_re       : register bus write / read request
//   bus_ack              : one-cycle completion from the register bus
// ---------------------------------------------------------------------------
module spi_dev_ctrl_bus
    import spi_dev_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  bus_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              busy,
    output logic              rd_done,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic              bus_ack
);

    logic              we_q,    we_d;
    logic              re_q,    re_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        wdata_q, wdata_d;

    assign busy    = we_q | re_q;
    // An ack with nothing in flight is ignored.
    assign rd_done = re_q & bus_ack;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        we_d    = we_q;
        re_d    = re_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (busy) begin
            // Request stays asserted through the ack cycle, then drops.
            if (bus_ack) begin
                we_d = 1'b0;
                re_d = 1'b0;
            end
        end else begin
            case (req_op)
                OP_WR: begin
                    we_d    = 1'b1;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                end
                OP_RD: begin
                    re_d   = 1'b1;
                    addr_d = req_addr;
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            re_q    <= re_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus_we    = we_q;
    assign bus_re    = re_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: rtl/spi_dev_ctrl.sv
// ---------------------------------------------------------------------------
// spi_dev_ctrl
// Frame decoder sitting between an SPI device core and a register bus.
// Frame: command byte (WRITE/READ), address MSB, address LSB, payload.
// Writes are issued per received payload byte with auto-increment. Reads
// fetch the addressed byte after the LSB, skip one dummy byte and then
// prefetch the next byte on every received byte, so data appears on MISO
// starting with the byte after the dummy. Overrun and underrun are recorded
// in sticky flags that are reported as the first MISO byte of the next frame.
//
// Ports
//   clk, rst_n              : clock, asynchronous active-low reset
//   usr_rx_data, usr_rx_stb : byte received from the SPI core, valid strobe
//   usr_tx_data, usr_tx_ack : byte offered to the SPI core, latch pulse
//   csn_fall, csn_rise      : synchronized chip-select edge pulses
//   bus_addr/wdata/we/re    : register bus request (master side)
//   bus_rdata, bus_ack      : register bus completion, read data
//   err_ovr, err_udr        : sticky overrun / underrun flags
// ---------------------------------------------------------------------------
module spi_dev_ctrl
    import spi_dev_ctrl_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        usr_rx_data,
    input  logic              usr_rx_stb,
    output logic [7:0]        usr_tx_data,
    input  logic              usr_tx_ack,
    input  logic              csn_rise,
    input  logic              csn_fall,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack,
    output logic              err_ovr,
    output logic              err_udr
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              is_rd_q, is_rd_d;
    logic [7:0]        tx_q,    tx_d;
    logic              ovr_q,   ovr_d;
    logic              udr_q,   udr_d;

    bus_op_t           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              busy;
    logic              rd_done;

    // Address assembly: bits above ADDR_W in the received 16-bit address are
    // dropped by truncating the 16-bit intermediate.
    logic [15:0]       addr_hi_ext;
    logic [15:0]       addr_full_ext;
    logic [ADDR_W-1:0] addr_rx_hi;
    logic [ADDR_W-1:0] addr_rx_full;
    logic [ADDR_W-1:0] addr_inc;

    assign addr_hi_ext   = {usr_rx_data, 8'h00};
    // After ADDR_H the low byte of addr_q is zero, so OR-ing in the LSB works.
    assign addr_full_ext = 16'(addr_q) | {8'h00, usr_rx_data};
    assign addr_rx_hi    = addr_hi_ext[ADDR_W-1:0];
    assign addr_rx_full  = addr_full_ext[ADDR_W-1:0];
    // Natural wrap modulo 2^ADDR_W.
    assign addr_inc      = addr_q + ADDR_W'(1);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        is_rd_d  = is_rd_q;
        tx_d     = tx_q;
        ovr_d    = ovr_q;
        udr_d    = udr_q;
        req_op   = OP_NONE;
        req_addr = addr_q;

        // Read completion is independent of the frame position: the address
        // always advances, but only a read belonging to the active read phase
        // may replace the byte offered on MISO.
        if (rd_done) begin
            addr_d = addr_inc;
            if (state_q == ST_RDUMMY || state_q == ST_RDATA) begin
                tx_d = bus_rdata;
            end
        end

        if (state_q == ST_IDLE) begin
            tx_d = status_byte(udr_q, ovr_q);
        end

        // Core took the byte before the prefetch finished: stale data goes out.
        if (state_q == ST_RDATA && usr_tx_ack && busy) begin
            udr_d = 1'b1;
        end

        if (csn_fall) begin
            // The core latches the status byte in this same cycle (tx_q is
            // still the IDLE value), so clearing the flags here is safe.
            // A coincident usr_rx_stb is dropped.
            state_d = ST_CMD;
            ovr_d   = 1'b0;
            udr_d   = 1'b0;
        end else if (csn_rise) begin
            state_d = ST_IDLE;
        end else if (usr_rx_stb) begin
            case (state_q)
                ST_CMD: begin
                    if (busy) begin
                        ovr_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else if (is_valid_cmd(usr_rx_data)) begin
                        is_rd_d = (usr_rx_data == CMD_READ);
                        state_d = ST_ADDR_H;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_ADDR_H: begin
                    addr_d  = addr_rx_hi;
                    state_d = ST_ADDR_L;
                end
                ST_ADDR_L: begin
                    if (busy) begin
                        ovr_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_rx_full;
                        if (is_rd_q) begin
                            req_op   = OP_RD;
                            req_addr = addr_rx_full;
                            state_d  = ST_RDUMMY;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (busy) begin
                        ovr_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        req_op = OP_WR;
                        addr_d = addr_inc;
                    end
                end
                ST_RDUMMY: begin
                    state_d = ST_RDATA;
                end
                ST_RDATA: begin
                    // Prefetch for the next MISO byte; address advances on ack.
                    if (busy) begin
                        ovr_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        req_op = OP_RD;
                    end
                end
                default: ; // IDLE and DRAIN ignore received bytes
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            is_rd_q <= 1'b0;
            tx_q    <= 8'h00;
            ovr_q   <= 1'b0;
            udr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            is_rd_q <= is_rd_d;
            tx_q    <= tx_d;
            ovr_q   <= ovr_d;
            udr_q   <= udr_d;
        end
    end

    spi_dev_ctrl_bus #(
        .ADDR_W (ADDR_W)
    ) u_bus (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (usr_rx_data),
        .busy      (busy),
        .rd_done   (rd_done),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_ack   (bus_ack)
    );

    assign usr_tx_data = tx_q;
    assign err_ovr     = ovr_q;
    assign err_udr     = udr_q;

endmodule

// File: tb/tb_spi_dev_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_dev_ctrl
// Bench acting as both the SPI device core (byte strobes, tx latch pulses)
// and the register bus slave (programmable ack delay, small read memory).
// Expected bus writes and MISO bytes are queued when frames are built and
// popped when the DUT produces them.
// ---------------------------------------------------------------------------
module tb_spi_dev_ctrl;

    localparam int ADDR_W = 16;

    logic              clk;
    logic              rst_n;
    logic [7:0]        usr_rx_data;
    logic              usr_rx_stb;
    logic [7:0]        usr_tx_data;
    logic              usr_tx_ack;
    logic              csn_rise;
    logic              csn_fall;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic              bus_we;
    logic              bus_re;
    logic [7:0]        bus_rdata;
    logic              bus_ack;
    logic              err_ovr;
    logic              err_udr;

    spi_dev_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .usr_rx_data (usr_rx_data),
        .usr_rx_stb  (usr_rx_stb),
        .usr_tx_data (usr_tx_data),
        .usr_tx_ack  (usr_tx_ack),
        .csn_rise    (csn_rise),
        .csn_fall    (csn_fall),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_we      (bus_we),
        .bus_re      (bus_re),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack),
        .err_ovr     (err_ovr),
        .err_udr     (err_udr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboards and counters ----------------
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    typedef struct packed {
        logic       care;
        logic [7:0] val;
    } miso_exp_t;

    typedef struct {
        logic [7:0]  ah, al, d0, d1;
        logic [15:0] exp_a0, exp_a1;
    } wr_vec_t;

    wr_exp_t    exp_wr[$];
    miso_exp_t  miso_sb[$];
    logic [7:0] rx_bytes[$];
    logic [7:0] mem [int];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_bus  = 0;
    int ack_delay = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- register bus slave ----------------
    int                cnt;
    logic [ADDR_W-1:0] first_addr;
    logic [7:0]        first_wdata;

    initial begin
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        cnt       = 0;
        forever begin
            @(negedge clk);
            if (bus_ack) begin
                bus_ack = 1'b0;
                cnt     = 0;
            end else if (!rst_n || !(bus_we || bus_re)) begin
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 1) begin
                    first_addr  = bus_addr;
                    first_wdata = bus_wdata;
                end
                if (cnt >= ack_delay) begin
                    check("we_re_exclusive", 32'(bus_we & bus_re), 32'd0);
                    check("req_addr_stable", 32'(bus_addr), 32'(first_addr));
                    check("req_wdata_stable", 32'(bus_wdata), 32'(first_wdata));
                    if (bus_re) begin
                        bus_rdata = mem.exists(int'(bus_addr)) ? mem[int'(bus_addr)] : 8'hEE;
                    end else if (exp_wr.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_write: got 0x%0h@0x%0h, expected none", bus_wdata, bus_addr);
                    end else begin
                        wr_exp_t e;
                        e = exp_wr.pop_front();
                        check("write_addr", 32'(bus_addr), 32'(e.addr));
                        check("write_data", 32'(bus_wdata), 32'(e.data));
                    end
                    bus_ack = 1'b1;
                    n_bus++;
                end
            end
        end
    end

    // ---------------- SPI core side ----------------
    task automatic push_miso(input logic care, input logic [7:0] val);
        miso_exp_t m;
        m.care = care;
        m.val  = val;
        miso_sb.push_back(m);
    endtask

    // Core latches usr_tx_data for the next byte.
    task automatic tx_slot();
        @(negedge clk);
        if (miso_sb.size() != 0) begin
            miso_exp_t m;
            m = miso_sb.pop_front();
            if (m.care) check("miso_byte", 32'(usr_tx_data), 32'(m.val));
        end
        usr_tx_ack = 1'b1;
        @(negedge clk);
        usr_tx_ack = 1'b0;
    endtask

    task automatic start_frame();
        @(negedge clk);
        if (miso_sb.size() != 0) begin
            miso_exp_t m;
            m = miso_sb.pop_front();
            if (m.care) check("miso_status", 32'(usr_tx_data), 32'(m.val));
        end
        csn_fall   = 1'b1;
        usr_tx_ack = 1'b1;
        @(negedge clk);
        csn_fall   = 1'b0;
        usr_tx_ack = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit next_slot);
        repeat (14) @(negedge clk);
        usr_rx_data = b;
        usr_rx_stb  = 1'b1;
        @(negedge clk);
        usr_rx_stb  = 1'b0;
        if (next_slot) begin
            repeat (6) @(negedge clk);
            tx_slot();
        end
    endtask

    task automatic wait_bus_idle();
        int n = 0;
        while ((bus_we || bus_re) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bus_idle_timeout", 32'(bus_we | bus_re), 32'd0);
    endtask

    task automatic end_frame();
        repeat (10) @(negedge clk);
        csn_rise = 1'b1;
        @(negedge clk);
        csn_rise = 1'b0;
        wait_bus_idle();
        repeat (3) @(negedge clk);
    endtask

    task automatic run_frame();
        int n;
        start_frame();
        n = rx_bytes.size();
        for (int i = 0; i < n; i++) begin
            send_byte(rx_bytes.pop_front(), i != n - 1);
        end
        end_frame();
        check("miso_sb_drained", 32'(miso_sb.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, 32'(usr_tx_data), 32'd0);
        check({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
        check({tag, "_bus_wdata"}, 32'(bus_wdata), 32'd0);
        check({tag, "_bus_we"}, 32'(bus_we), 32'd0);
        check({tag, "_bus_re"}, 32'(bus_re), 32'd0);
        check({tag, "_err_ovr"}, 32'(err_ovr), 32'd0);
        check({tag, "_err_udr"}, 32'(err_udr), 32'd0);
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- main test ----------------
    wr_vec_t wr_tab[3];
    int      n_bus_before;

    initial begin
        wr_tab[0] = '{8'h12, 8'h34, 8'hAA, 8'hBB, 16'h1234, 16'h1235};
        wr_tab[1] = '{8'hFF, 8'hFF, 8'hC1, 8'hC2, 16'hFFFF, 16'h0000};
        wr_tab[2] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 16'h00FF, 16'h0100};

        mem[32'h0010] = 8'h5A;
        mem[32'h0011] = 8'h6B;
        mem[32'h0020] = 8'hC3;

        rst_n       = 1'b0;
        usr_rx_data = 8'h00;
        usr_rx_stb  = 1'b0;
        usr_tx_ack  = 1'b0;
        csn_rise    = 1'b0;
        csn_fall    = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Write frames from the table: two payload bytes each.
        for (int i = 0; i < 3; i++) begin
            wr_exp_t e;
            rx_bytes = '{8'h01, wr_tab[i].ah, wr_tab[i].al, wr_tab[i].d0, wr_tab[i].d1};
            push_miso(1'b1, 8'h00);
            for (int k = 0; k < 4; k++) push_miso(1'b0, 8'h00);
            e.addr = wr_tab[i].exp_a0; e.data = wr_tab[i].d0; exp_wr.push_back(e);
            e.addr = wr_tab[i].exp_a1; e.data = wr_tab[i].d1; exp_wr.push_back(e);
            run_frame();
            check("wr_err_ovr", 32'(err_ovr), 32'd0);
            check("wr_err_udr", 32'(err_udr), 32'd0);
        end

        // Directed read, 3-cycle ack: MISO bytes 4 and 5 carry 0x0010/0x0011.
        ack_delay = 3;
        rx_bytes = '{8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        push_miso(1'b1, 8'h00);
        for (int k = 0; k < 3; k++) push_miso(1'b0, 8'h00);
        push_miso(1'b1, 8'h5A);
        push_miso(1'b1, 8'h6B);
        run_frame();
        check("rd_err_udr", 32'(err_udr), 32'd0);

        // Slow read: prefetch still pending when core latches byte 5.
        ack_delay = 12;
        rx_bytes = '{8'h02, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        push_miso(1'b1, 8'h00);
        for (int k = 0; k < 3; k++) push_miso(1'b0, 8'h00);
        push_miso(1'b1, 8'hC3);
        push_miso(1'b1, 8'hC3);
        run_frame();
        check("udr_err_udr", 32'(err_udr), 32'd1);
        check("udr_err_ovr", 32'(err_ovr), 32'd0);

        // Invalid command: status reports underrun, no bus traffic, flags cleared.
        ack_delay = 3;
        n_bus_before = n_bus;
        rx_bytes = '{8'h07, 8'h01, 8'h02, 8'h03};
        push_miso(1'b1, 8'h02);
        for (int k = 0; k < 3; k++) push_miso(1'b0, 8'h00);
        run_frame();
        check("inv_bus_cycles", 32'(n_bus - n_bus_before), 32'd0);
        check("inv_err_udr", 32'(err_udr), 32'd0);

        // Overrun: ack withheld 40 cycles, next byte arrives meanwhile.
        ack_delay = 40;
        begin
            wr_exp_t e;
            e.addr = 16'h2000; e.data = 8'h11; exp_wr.push_back(e);
        end
        rx_bytes = '{8'h01, 8'h20, 8'h00, 8'h11, 8'h22};
        push_miso(1'b1, 8'h00);
        for (int k = 0; k < 4; k++) push_miso(1'b0, 8'h00);
        run_frame();
        check("ovr_err_ovr", 32'(err_ovr), 32'd1);

        // Next frame reports the overrun, then flags are clear.
        ack_delay = 3;
        begin
            wr_exp_t e;
            e.addr = 16'h2010; e.data = 8'h33; exp_wr.push_back(e);
        end
        rx_bytes = '{8'h01, 8'h20, 8'h10, 8'h33};
        push_miso(1'b1, 8'h01);
        for (int k = 0; k < 3; k++) push_miso(1'b0, 8'h00);
        run_frame();
        check("post_ovr_err_ovr", 32'(err_ovr), 32'd0);

        // Reset asserted while a read is in flight.
        ack_delay = 10;
        n_bus_before = n_bus;
        start_frame();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h30, 1'b0);
        check("midrd_bus_re", 32'(bus_re), 32'd1);
        check("midrd_bus_addr", 32'(bus_addr), 32'h0030);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrd_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrd_no_ack", 32'(n_bus - n_bus_before), 32'd0);
        check("midrd_idle_re", 32'(bus_re), 32'd0);

        // Recovery after reset.
        ack_delay = 3;
        begin
            wr_exp_t e;
            e.addr = 16'h0005; e.data = 8'h77; exp_wr.push_back(e);
        end
        rx_bytes = '{8'h01, 8'h00, 8'h05, 8'h77};
        push_miso(1'b1, 8'h00);
        for (int k = 0; k < 3; k++) push_miso(1'b0, 8'h00);
        run_frame();

        check("wr_sb_drained", 32'(exp_wr.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
